// File: rtl/eim_bus_front.sv
// EIM bus front end: synchronizes the i.MX EIM pins into clk and
// sequences each bus cycle into single-cycle register-file strobes.
module eim_bus_front #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              eim_cs0_n,
  input  logic              eim_lba_n,
  input  logic              eim_wr_n,
  input  logic              eim_oe_n,
  input  logic [DATA_W-1:0] da_in,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_stb,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] dout,
  output logic              da_t,
  output logic              eim_wait_n,
  output logic              err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CMD,
    FETCH,
    READ,
    WRITE
  } state_t;

  state_t state, nxt;

  logic [SYNC_STAGES-1:0][3:0]        ctl_sync;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] da_sync;
  logic [3:0]                         ctl_hist;
  logic [3:0]                         ctl;
  logic [DATA_W-1:0]                  da_s;

  logic cs_s, lba_s, wr_s, oe_s;
  logic cs_rise, lba_rise, wr_rise, oe_rise, lba_fall;

  logic [CW-1:0]     cnt;
  logic              at_limit;
  logic              counting;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rd_req;
  logic              wr_go;
  logic              tmo;

  // Data rides a chain of the same depth so it stays aligned with controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_sync <= '1;
      da_sync  <= '0;
      ctl_hist <= '1;
    end else begin
      ctl_sync <= {ctl_sync[SYNC_STAGES-2:0],
                   {eim_cs0_n, eim_lba_n, eim_wr_n, eim_oe_n}};
      da_sync  <= {da_sync[SYNC_STAGES-2:0], da_in};
      ctl_hist <= ctl_sync[SYNC_STAGES-1];
    end
  end

  assign ctl  = ctl_sync[SYNC_STAGES-1];
  assign da_s = da_sync[SYNC_STAGES-1];

  assign cs_s  = ctl[3];
  assign lba_s = ctl[2];
  assign wr_s  = ctl[1];
  assign oe_s  = ctl[0];

  assign cs_rise  = ctl[3] & ~ctl_hist[3];
  assign lba_rise = ctl[2] & ~ctl_hist[2];
  assign wr_rise  = ctl[1] & ~ctl_hist[1];
  assign oe_rise  = ctl[0] & ~ctl_hist[0];
  assign lba_fall = ~ctl[2] & ctl_hist[2];

  assign at_limit = (cnt == CW'(TIMEOUT - 1));
  assign counting = (state == ADDR) || (state == CMD) ||
                    (state == WRITE) || (state == READ);

  always_comb begin
    nxt    = state;
    rd_req = 1'b0;
    wr_go  = 1'b0;
    tmo    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!cs_s && !lba_s) nxt = ADDR;
      end
      ADDR: begin
        if (cs_rise) nxt = IDLE;
        else if (lba_rise) begin
          rd_req = 1'b1;
          nxt    = FETCH;
        end else if (at_limit) tmo = 1'b1;
      end
      FETCH: begin
        nxt = cs_rise ? IDLE : CMD;
      end
      CMD: begin
        if (cs_rise) nxt = IDLE;
        else if (!wr_s) nxt = WRITE;
        else if (!oe_s) nxt = READ;
        else if (lba_fall) nxt = ADDR;
        else if (at_limit) tmo = 1'b1;
      end
      WRITE: begin
        if (wr_rise) begin
          wr_go = 1'b1;
          nxt   = cs_rise ? IDLE : CMD;
        end else if (cs_rise) nxt = IDLE;
        else if (at_limit) tmo = 1'b1;
      end
      READ: begin
        if (cs_rise) nxt = IDLE;
        else if (oe_rise) nxt = CMD;
        else if (at_limit) tmo = 1'b1;
      end
      default: nxt = IDLE;
    endcase
    if (tmo) nxt = IDLE;
  end

  // The read is issued combinationally so rd_data lands during FETCH.
  assign rd_stb  = rd_req;
  assign rd_addr = addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      addr        <= '0;
      wdata       <= '0;
      wr_stb      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      dout        <= '0;
      da_t        <= 1'b1;
      eim_wait_n  <= 1'b1;
      err_timeout <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state) cnt <= '0;
      else if (counting) cnt <= cnt + 1'b1;
      if (state == ADDR && !lba_s) addr <= ADDR_W'(da_s);
      if (state == WRITE && !wr_s) wdata <= da_s;
      wr_stb <= wr_go;
      if (wr_go) begin
        wr_addr <= addr;
        wr_data <= wdata;
      end
      if (state == FETCH) dout <= rd_data;
      eim_wait_n <= ~rd_req;
      da_t       <= ~((nxt == READ) && !oe_s);
      if (tmo) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eim_bus_front.sv
// Directed bench for eim_bus_front: write, read, abort, timeout,
// back-to-back and asynchronous reset scenarios.
module tb_eim_bus_front;

  logic       clk;
  logic       rst;
  logic       cs, lba, wr, oe;
  logic [7:0] da;
  logic       wr_stb, rd_stb;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic [7:0] rd_data;
  logic [7:0] dout;
  logic       da_t, eim_wait_n, err_timeout;

  int checks;
  int errors;
  int wr_cnt;
  int rd_cnt;
  int overlap;
  int w0, r0;
  logic [7:0] last_wa, last_wd;

  eim_bus_front #(
    .ADDR_W(8),
    .DATA_W(8),
    .SYNC_STAGES(2),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .eim_cs0_n(cs),
    .eim_lba_n(lba),
    .eim_wr_n(wr),
    .eim_oe_n(oe),
    .da_in(da),
    .wr_stb(wr_stb),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_stb(rd_stb),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .dout(dout),
    .da_t(da_t),
    .eim_wait_n(eim_wait_n),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: registered read, one cycle after rd_stb.
  initial rd_data = 8'h00;
  always @(posedge clk) begin
    if (rd_stb) rd_data <= (rd_addr == 8'h05) ? 8'h3C : 8'hE1;
  end

  always @(negedge clk) begin
    if (wr_stb) begin
      wr_cnt  = wr_cnt + 1;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
    if (rd_stb) rd_cnt = rd_cnt + 1;
    if (wr_stb && rd_stb) overlap = overlap + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    lba = 1'b0;
    da  = a;
    cyc(4);
    lba = 1'b1;
    cyc(4);
    wr = 1'b0;
    da = d;
    cyc(4);
    wr = 1'b1;
    cyc(4);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    wr_cnt  = 0;
    rd_cnt  = 0;
    overlap = 0;
    last_wa = 8'h00;
    last_wd = 8'h00;
    rst = 1'b1;
    cs  = 1'b1;
    lba = 1'b1;
    wr  = 1'b1;
    oe  = 1'b1;
    da  = 8'h00;
    cyc(3);
    chk("rst_wr_stb", 32'(wr_stb), 32'h0);
    chk("rst_rd_stb", 32'(rd_stb), 32'h0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_rd_addr", 32'(rd_addr), 32'h0);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_da_t", 32'(da_t), 32'h1);
    chk("rst_wait_n", 32'(eim_wait_n), 32'h1);
    chk("rst_err", 32'(err_timeout), 32'h0);
    rst = 1'b0;
    cyc(3);

    // Single write: addr 0x03, data 0xA5
    cs  = 1'b0;
    lba = 1'b0;
    da  = 8'h03;
    cyc(4);
    lba = 1'b1;
    cyc(4);
    r0 = rd_cnt;
    chk("wr_spec_rd", 32'(rd_cnt), 32'd1);
    wr = 1'b0;
    da = 8'hA5;
    cyc(4);
    wr = 1'b1;
    cyc(2);
    chk("wr_early", 32'(wr_stb), 32'h0);
    tick();
    chk("wr_stb", 32'(wr_stb), 32'h1);
    chk("wr_addr", 32'(wr_addr), 32'h03);
    chk("wr_data", 32'(wr_data), 32'hA5);
    chk("wr_no_rd", 32'(rd_stb), 32'h0);
    tick();
    chk("wr_pulse", 32'(wr_stb), 32'h0);
    cs = 1'b1;
    cyc(4);
    chk("wr_count", 32'(wr_cnt), 32'd1);
    chk("wr_rd_quiet", 32'(rd_cnt - r0), 32'd0);

    // Read: addr 0x05 returns 0x3C
    cs  = 1'b0;
    lba = 1'b0;
    da  = 8'h05;
    cyc(4);
    lba = 1'b1;
    cyc(2);
    chk("rd_stb", 32'(rd_stb), 32'h1);
    chk("rd_addr", 32'(rd_addr), 32'h05);
    chk("rd_wait_pre", 32'(eim_wait_n), 32'h1);
    tick();
    chk("rd_pulse", 32'(rd_stb), 32'h0);
    chk("rd_wait_low", 32'(eim_wait_n), 32'h0);
    tick();
    chk("rd_wait_rel", 32'(eim_wait_n), 32'h1);
    chk("rd_dout", 32'(dout), 32'h3C);
    oe = 1'b0;
    cyc(2);
    chk("rd_dat_hiz", 32'(da_t), 32'h1);
    tick();
    chk("rd_dat_drv", 32'(da_t), 32'h0);
    oe = 1'b1;
    cyc(2);
    chk("rd_dat_hold", 32'(da_t), 32'h0);
    tick();
    chk("rd_dat_off", 32'(da_t), 32'h1);
    cs = 1'b1;
    cyc(4);

    // Abort: cs rises in WRITE with wr still low
    w0  = wr_cnt;
    cs  = 1'b0;
    lba = 1'b0;
    da  = 8'h07;
    cyc(4);
    lba = 1'b1;
    cyc(4);
    wr = 1'b0;
    da = 8'h99;
    cyc(4);
    cs = 1'b1;
    cyc(4);
    chk("ab_no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("ab_da_t", 32'(da_t), 32'h1);
    wr = 1'b1;
    cyc(4);
    chk("ab_idle", 32'(wr_cnt - w0), 32'd0);

    // Timeout: 16 idle cycles in CMD
    cs  = 1'b0;
    lba = 1'b0;
    da  = 8'h09;
    cyc(4);
    lba = 1'b1;
    cyc(19);
    chk("to_early", 32'(err_timeout), 32'h0);
    tick();
    chk("to_set", 32'(err_timeout), 32'h1);
    chk("to_da_t", 32'(da_t), 32'h1);
    cyc(4);
    chk("to_sticky", 32'(err_timeout), 32'h1);
    cs = 1'b1;
    cyc(3);
    w0 = wr_cnt;
    cs = 1'b0;
    do_write(8'h0B, 8'h5A);
    cs = 1'b1;
    cyc(4);
    chk("to_wr_cnt", 32'(wr_cnt - w0), 32'd1);
    chk("to_wr_pair", 32'({last_wa, last_wd}), 32'h0B5A);
    chk("to_still", 32'(err_timeout), 32'h1);

    // Back-to-back writes without cs rising
    w0 = wr_cnt;
    cs = 1'b0;
    do_write(8'h01, 8'h11);
    chk("b2b_pair1", 32'({last_wa, last_wd}), 32'h0111);
    do_write(8'h02, 8'h22);
    chk("b2b_pair2", 32'({last_wa, last_wd}), 32'h0222);
    chk("b2b_cnt", 32'(wr_cnt - w0), 32'd2);
    cs = 1'b1;
    cyc(4);

    // Reset in the middle of a read
    cs  = 1'b0;
    lba = 1'b0;
    da  = 8'h05;
    cyc(4);
    lba = 1'b1;
    cyc(4);
    chk("mr_dout", 32'(dout), 32'h3C);
    oe = 1'b0;
    cyc(4);
    chk("mr_drive", 32'(da_t), 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_da_t", 32'(da_t), 32'h1);
    chk("mr_dout0", 32'(dout), 32'h0);
    chk("mr_wait", 32'(eim_wait_n), 32'h1);
    chk("mr_err0", 32'(err_timeout), 32'h0);
    cyc(2);
    rst = 1'b0;
    w0 = wr_cnt;
    r0 = rd_cnt;
    cyc(8);
    oe = 1'b1;
    wr = 1'b0;
    cyc(4);
    wr = 1'b1;
    cyc(4);
    chk("mr_no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("mr_no_rd", 32'(rd_cnt - r0), 32'd0);
    chk("mr_idle_t", 32'(da_t), 32'h1);
    lba = 1'b0;
    da  = 8'h05;
    cyc(4);
    lba = 1'b1;
    cyc(4);
    chk("mr_new_rd", 32'(rd_cnt - r0), 32'd1);
    chk("mr_new_dout", 32'(dout), 32'h3C);
    cs = 1'b1;
    cyc(4);

    chk("no_overlap", 32'(overlap), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
